// File: rtl/cpu_sram_responder_pkg.sv
// Shared constants and address helpers for the CPU SRAM responder.
// Imported by the responder top and its RAM.
package cpu_sram_responder_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h1c00_0000;

   localparam logic ST_INIT  = 1'b0;
   localparam logic ST_READY = 1'b1;

   // Byte address lands inside the 2**aw word window starting at base.
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          aw);
      logic [31:0] off;
      off = addr - base;
      return (off >> (aw + 2)) == 32'd0;
   endfunction

   // Word offset from base; caller keeps the low aw bits.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      logic [31:0] off;
      off = addr - base;
      return off >> 2;
   endfunction

endpackage

// File: rtl/cpu_sram_responder_ram.sv
// Word RAM with one write port and two registered read ports.
// Reads see same-cycle write data on an address match.
module ram_2r1w
   import cpu_sram_responder_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr0_i,
   input  logic          rzero0_i,
   output logic [DW-1:0] rdata0_o,
   input  logic [AW-1:0] raddr1_i,
   input  logic          rzero1_i,
   output logic [DW-1:0] rdata1_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rd0_q;
   logic [DW-1:0] rd1_q;

   // Storage array, written by whichever source the top selects.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port 0: forced zero, bypassed write data, or stored word.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd0_q <= '0;
      end else if (rzero0_i) begin
         rd0_q <= '0;
      end else if (we_i && (waddr_i == raddr0_i)) begin
         rd0_q <= wdata_i;
      end else begin
         rd0_q <= mem_q[raddr0_i];
      end
   end

   // Read port 1: same policy as port 0.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd1_q <= '0;
      end else if (rzero1_i) begin
         rd1_q <= '0;
      end else if (we_i && (waddr_i == raddr1_i)) begin
         rd1_q <= wdata_i;
      end else begin
         rd1_q <= mem_q[raddr1_i];
      end
   end

   assign rdata0_o = rd0_q;
   assign rdata1_o = rd1_q;

endmodule

// File: rtl/cpu_sram_responder.sv
// Program memory behind the CPU inst/data SRAM ports.
// Clears the RAM after reset, then serves reads/writes and counts bad accesses.
module cpu_sram_responder
   import cpu_sram_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          AW        = 10,
   parameter int          ERR_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst_sram_we,
   input  logic [31:0]      inst_sram_addr,
   input  logic [31:0]      inst_sram_wdata,
   output logic [31:0]      inst_sram_rdata,
   input  logic             data_sram_we,
   input  logic [31:0]      data_sram_addr,
   input  logic [31:0]      data_sram_wdata,
   output logic [31:0]      data_sram_rdata,
   output logic             init_done,
   output logic [ERR_W-1:0] err_count
);

   logic             state_q, state_d;
   logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic             inst_in, data_in;
   logic [31:0]      inst_off, data_off;
   logic [AW-1:0]    inst_idx, data_idx;

   logic             ram_we;
   logic [AW-1:0]    ram_waddr;
   logic [31:0]      ram_wdata;
   logic             inst_zero, data_zero;

   logic [1:0]       err_inc;
   logic [ERR_W:0]   err_sum;
   logic             unused_bits;

   assign inst_in  = in_range(inst_sram_addr, BASE_ADDR, AW);
   assign data_in  = in_range(data_sram_addr, BASE_ADDR, AW);
   assign inst_off = word_index(inst_sram_addr, BASE_ADDR);
   assign data_off = word_index(data_sram_addr, BASE_ADDR);
   assign inst_idx = inst_off[AW-1:0];
   assign data_idx = data_off[AW-1:0];

   assign unused_bits = ^{inst_sram_wdata,
                          inst_off[31:AW],
                          data_off[31:AW]};

   // FSM state and clear pointer; reset restarts the clear at word 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_INIT;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // Next state: walk every word once, then stay READY until reset.
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         ST_INIT: begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == {AW{1'b1}}) begin
               state_d = ST_READY;
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   // Outputs: clear writes while INIT, data-port writes and reads when READY.
   always_comb begin
      ram_we    = 1'b1;
      ram_waddr = clr_ptr_q;
      ram_wdata = '0;
      inst_zero = 1'b1;
      data_zero = 1'b1;
      if (state_q == ST_READY) begin
         ram_we    = data_sram_we & data_in;
         ram_waddr = data_idx;
         ram_wdata = data_sram_wdata;
         inst_zero = ~inst_in;
         data_zero = ~data_in;
      end
   end

   // Error increment and saturating sum; frozen while clearing.
   always_comb begin
      err_inc = 2'(inst_sram_we) + 2'(~inst_in) + 2'(~data_in);
      err_sum = {1'b0, err_q} + (ERR_W+1)'(err_inc);
      err_d   = err_q;
      if (state_q == ST_READY) begin
         err_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
      end
   end

   // Error counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   ram_2r1w #(
      .AW (AW),
      .DW (32)
   ) u_ram (
      .clk_i    (clk),
      .rst_i    (reset),
      .we_i     (ram_we),
      .waddr_i  (ram_waddr),
      .wdata_i  (ram_wdata),
      .raddr0_i (inst_idx),
      .rzero0_i (inst_zero),
      .rdata0_o (inst_sram_rdata),
      .raddr1_i (data_idx),
      .rzero1_i (data_zero),
      .rdata1_o (data_sram_rdata)
   );

   assign init_done = (state_q == ST_READY);
   assign err_count = err_q;

endmodule
